jtframe_cen_bank: RTL and testbench



---
 rtl/jtframe_cen_bank.sv | 128 ++++++++++++
 tb/tb_jtframe_cen_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/jtframe_cen_bank.sv
// Bank of fractional clock-enable generators.
// Each channel pulses at clk*N/M and emits a matching square wave.
module jtframe_cen_bank #(
  parameter int CH       = 4,
  parameter int W        = 10,
  parameter int INIT_N   = 1,
  parameter int INIT_M   = 2,
  parameter int LOCK_DLY = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_ch,
  input  logic [W-1:0]  cfg_n,
  input  logic [W-1:0]  cfg_m,
  input  logic          sync,
  output logic [CH-1:0] cen,
  output logic [CH-1:0] div,
  output logic          locked
);

  localparam logic [W-1:0] N0   = W'(INIT_N);
  localparam logic [W-1:0] M0   = W'(INIT_M);
  localparam logic [15:0]  LOCK = 16'(LOCK_DLY);
  localparam logic [4:0]   CH5  = 5'(CH);

  logic [W-1:0]  n_q   [CH];
  logic [W-1:0]  n_d   [CH];
  logic [W-1:0]  m_q   [CH];
  logic [W-1:0]  m_d   [CH];
  logic [W:0]    acc_q [CH];
  logic [W:0]    acc_d [CH];
  logic [W:0]    sum_w [CH];
  logic [CH-1:0] en_w;
  logic [CH-1:0] cen_q, cen_d;
  logic [CH-1:0] div_q, div_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          locked_q, locked_d;
  logic          wr_ok;

  // A write to a channel beyond the bank is dropped entirely.
  always_comb begin
    wr_ok = cfg_we && ({1'b0, cfg_ch} < CH5);
  end

  // Accumulator step: N clamped to M so a pulse never gets skipped.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      en_w[i]  = (n_q[i] != '0) && (m_q[i] != '0);
      sum_w[i] = acc_q[i] +
                 ((n_q[i] > m_q[i]) ? {1'b0, m_q[i]}
                                    : {1'b0, n_q[i]});
    end
  end

  // Per-channel next state; writes and sync override the step.
  always_comb begin
    cen_d = '0;
    div_d = div_q;
    for (int i = 0; i < CH; i++) begin
      n_d[i]   = n_q[i];
      m_d[i]   = m_q[i];
      acc_d[i] = '0;
      if (en_w[i]) begin
        if (sum_w[i] >= {1'b0, m_q[i]}) begin
          acc_d[i] = sum_w[i] - {1'b0, m_q[i]};
          cen_d[i] = 1'b1;
          div_d[i] = ~div_q[i];
        end else begin
          acc_d[i] = sum_w[i];
        end
      end
      if (wr_ok && (cfg_ch == 4'(i))) begin
        n_d[i]   = cfg_n;
        m_d[i]   = cfg_m;
        acc_d[i] = '0;
        cen_d[i] = 1'b0;
        div_d[i] = 1'b0;
      end
      if (sync) begin
        acc_d[i] = '0;
        cen_d[i] = 1'b0;
        div_d[i] = 1'b0;
      end
    end
  end

  // Lock counter saturates; any clearing event drops locked at once.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_ok || sync) begin
      cnt_d = '0;
    end else if (cnt_q != LOCK) begin
      cnt_d = cnt_q + 16'd1;
    end
    locked_d = (cnt_d == LOCK);
  end

  // State registers with asynchronous reset to the init ratios.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        n_q[i]   <= N0;
        m_q[i]   <= M0;
        acc_q[i] <= '0;
      end
      cen_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        n_q[i]   <= n_d[i];
        m_q[i]   <= m_d[i];
        acc_q[i] <= acc_d[i];
      end
      cen_q    <= cen_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign cen    = cen_q;
  assign div    = div_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_jtframe_cen_bank.sv
// Directed bench for jtframe_cen_bank.
// Expected values are hand-derived from the N/M pulse rules.
module tb_jtframe_cen_bank;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [3:0]   cfg_ch;
  logic [W-1:0] cfg_n;
  logic [W-1:0] cfg_m;
  logic         sync;
  logic [3:0]   cen;
  logic [3:0]   div;
  logic         locked;

  int n_tot = 0;
  int n_bad = 0;

  jtframe_cen_bank #(
    .CH(4), .W(W), .INIT_N(1), .INIT_M(2), .LOCK_DLY(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_n(cfg_n), .cfg_m(cfg_m),
    .sync(sync),
    .cen(cen), .div(div), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] ch,
                    input int n, input int m);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_n  = W'(n);
    cfg_m  = W'(m);
    tick();
    cfg_we = 1'b0;
  endtask

  logic [3:0] cen_tab [8] = '{4'b0000, 4'b0000, 4'b0100,
                              4'b0011, 4'b0000, 4'b0100,
                              4'b0000, 4'b0111};
  logic [3:0] div_tab [8] = '{4'b0000, 4'b0000, 4'b0100,
                              4'b0111, 4'b0111, 4'b0011,
                              4'b0011, 4'b0100};

  initial begin
    int k;
    int pulses;
    int first;
    int last;
    int badsp;
    logic [3:0] e;

    rst_n  = 1'b0;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_n  = '0;
    cfg_m  = '0;
    sync   = 1'b0;

    repeat (2) tick();
    chk("rst_cen", 32'(cen), 32'h0);
    chk("rst_div", 32'(div), 32'h0);
    chk("rst_lock", 32'(locked), 32'h0);
    rst_n = 1'b1;

    // defaults 1/2 on every channel
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("def_cen", 32'(cen), (i % 2 == 0) ? 32'hF : 32'h0);
      chk("def_div", 32'(div), ((i / 2) % 2 == 1) ? 32'hF : 32'h0);
      chk("def_lock", 32'(locked), (i == 32) ? 32'h1 : 32'h0);
    end

    // ch1 -> 1/4, others keep running
    wr(4'd1, 1, 4);
    chk("wr1_cen", 32'(cen), 32'h0);
    chk("wr1_div", 32'(div), 32'h0);
    chk("wr1_lock", 32'(locked), 32'h0);
    for (int j = 1; j <= 32; j++) begin
      k = 33 + j;
      tick();
      e = (k % 2 == 0) ? 4'b1101 : 4'b0000;
      if (j % 4 == 0) e = e | 4'b0010;
      chk("r14_cen", 32'(cen), 32'(e));
      e = ((k / 2) % 2 == 1) ? 4'b1101 : 4'b0000;
      if ((j / 4) % 2 == 1) e = e | 4'b0010;
      chk("r14_div", 32'(div), 32'(e));
      chk("r14_lock", 32'(locked), (j == 32) ? 32'h1 : 32'h0);
    end

    // ch2 -> 3/8 fractional
    wr(4'd2, 3, 8);
    pulses = 0;
    first  = 0;
    last   = 0;
    badsp  = 0;
    for (int t = 1; t <= 800; t++) begin
      tick();
      if (cen[2]) begin
        pulses++;
        if (first == 0) first = t;
        if (last != 0 && (t - last < 2 || t - last > 3)) badsp++;
        last = t;
      end
    end
    chk("frac_cnt", 32'(pulses), 32'd300);
    chk("frac_first", 32'(first), 32'd3);
    chk("frac_space", 32'(badsp), 32'd0);
    chk("frac_lock", 32'(locked), 32'h1);

    // ch3 N>M clamps to every cycle
    wr(4'd3, 9, 5);
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("clamp_cen", 32'(cen[3]), 32'h1);
      chk("clamp_div", 32'(div[3]), 32'(t % 2));
    end
    // ch3 N=0 disables
    wr(4'd3, 0, 5);
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("dis_cen", 32'(cen[3]), 32'h0);
      chk("dis_div", 32'(div[3]), 32'h0);
    end

    // sync plus ch0 -> 1/4 in the same cycle
    sync = 1'b1;
    wr(4'd0, 1, 4);
    sync = 1'b0;
    chk("sync_cen", 32'(cen), 32'h0);
    chk("sync_div", 32'(div), 32'h0);
    chk("sync_lock", 32'(locked), 32'h0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("sync_cen_t", 32'(cen), 32'(cen_tab[j]));
      chk("sync_div_t", 32'(div), 32'(div_tab[j]));
    end
    repeat (24) tick();
    chk("sync_relock", 32'(locked), 32'h1);

    // out-of-range channel write is ignored
    wr(4'd7, 1, 2);
    chk("bad_lock", 32'(locked), 32'h1);
    chk("bad_cen33", 32'(cen), 32'h0);
    tick();
    chk("bad_cen34", 32'(cen), 32'h0);
    tick();
    chk("bad_cen35", 32'(cen), 32'b0100);
    tick();
    chk("bad_cen36", 32'(cen), 32'b0011);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cen", 32'(cen), 32'h0);
    chk("arst_div", 32'(div), 32'h0);
    chk("arst_lock", 32'(locked), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("init_cen1", 32'(cen), 32'h0);
    tick();
    chk("init_cen2", 32'(cen), 32'hF);
    chk("init_div2", 32'(div), 32'hF);
    chk("init_lock", 32'(locked), 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
